// File: rtl/div_booth_restoring.sv
// Iterative signed restoring divider, one quotient bit per clock.
// Operands are latched on start. The magnitudes go through WIDTH restoring
// steps, and the signs are applied afterwards. Latency is fixed at WIDTH+1
// cycles from the accepting edge to the done pulse.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; operands and magnitudes load on accept
// CALC  | one shift/trial-subtract step per cycle, WIDTH steps total
// FIX   | apply signs and special cases, write q/r/flags, pulse done
module div_booth_restoring #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             busy,
   output logic             done,
   output logic             dbz,
   output logic             ovf
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [WIDTH-1:0] a_lat;
   logic [WIDTH-1:0] b_lat;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH:0]   dvs;
   logic [CW-1:0]    cnt;

   logic [WIDTH:0]   b_ext;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH:0]   b_mag;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   trial;
   logic             trial_ok;
   logic             sign_a;
   logic             sign_b;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;
   logic             is_dbz;
   logic             is_ovf;

   // Operand magnitudes, the restoring step, and the sign/special-case fixup
   always_comb begin
      // |a| fits in WIDTH unsigned bits, including |-2^(WIDTH-1)|
      a_mag    = a[WIDTH-1] ? ({WIDTH{1'b0}} - a) : a;
      b_ext    = {b[WIDTH-1], b};
      b_mag    = b[WIDTH-1] ? ({(WIDTH+1){1'b0}} - b_ext) : b_ext;

      // rem < |b| <= 2^(WIDTH-1), so the shifted remainder stays below 2^WIDTH
      // and the WIDTH+1-bit difference carries a valid sign in its top bit
      rem_sh   = {rem, quo[WIDTH-1]};
      trial    = rem_sh - dvs;
      trial_ok = ~trial[WIDTH];

      sign_a   = a_lat[WIDTH-1];
      sign_b   = b_lat[WIDTH-1];
      is_dbz   = (b_lat == {WIDTH{1'b0}});
      is_ovf   = (a_lat == MOST_NEG) && (b_lat == {WIDTH{1'b1}});

      q_fix    = (sign_a ^ sign_b) ? ({WIDTH{1'b0}} - quo) : quo;
      r_fix    = sign_a ? ({WIDTH{1'b0}} - rem) : rem;
      if (is_dbz) begin
         q_fix = {WIDTH{1'b1}};
         r_fix = a_lat;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = CALC;
         CALC: if (cnt == {CW{1'b0}}) state_nxt = FIX;
         FIX:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: operand latch, iteration, and registered results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_lat <= '0;
         b_lat <= '0;
         rem   <= '0;
         quo   <= '0;
         dvs   <= '0;
         cnt   <= '0;
         q     <= '0;
         r     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         dbz   <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_lat <= a;
                  b_lat <= b;
                  quo   <= a_mag;
                  dvs   <= b_mag;
                  rem   <= '0;
                  cnt   <= CNT_LOAD;
                  busy  <= 1'b1;
               end
            end
            CALC: begin
               rem <= trial_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
               quo <= {quo[WIDTH-2:0], trial_ok};
               cnt <= cnt - 1'b1;
            end
            FIX: begin
               q    <= q_fix;
               r    <= is_ovf ? {WIDTH{1'b0}} : r_fix;
               dbz  <= is_dbz;
               ovf  <= is_ovf;
               done <= 1'b1;
               busy <= 1'b0;
            end
            default: begin
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_booth_restoring.sv
// Bench for div_booth_restoring: a reference model built on plain integer
// division, checked against the DUT every cycle, plus directed literal cases.
module tb_div_booth_restoring;

   localparam int W      = 4;
   localparam int LAT    = W + 1;
   localparam int MINV   = -(1 << (W - 1));
   localparam int MAXV   = (1 << (W - 1)) - 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [W-1:0] q;
   logic [W-1:0] r;
   logic         busy;
   logic         done;
   logic         dbz;
   logic         ovf;

   int tests = 0;
   int fails = 0;

   div_booth_restoring #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .q(q), .r(r), .busy(busy), .done(done), .dbz(dbz), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
      end
   endtask

   // Reference: truncating signed division with the two special cases
   function automatic void ref_div(input int av, input int bv,
                                   output int qv, output int rv,
                                   output int dz, output int ov);
      dz = 0;
      ov = 0;
      if (bv == 0) begin
         qv = -1; rv = av; dz = 1;
      end else if (av == MINV && bv == -1) begin
         qv = MINV; rv = 0; ov = 1;
      end else begin
         qv = av / bv; rv = av % bv;
      end
   endfunction

   function automatic int sx(input logic [W-1:0] v);
      return int'($signed(v));
   endfunction

   // Input samples as seen by the DUT at each rising edge
   int           edge_n = 0;
   logic         s_start = 1'b0;
   logic         s_rstn = 1'b0;
   logic [W-1:0] s_a = '0;
   logic [W-1:0] s_b = '0;

   always @(posedge clk) begin
      edge_n  <= edge_n + 1;
      s_start <= start;
      s_rstn  <= rst_n;
      s_a     <= a;
      s_b     <= b;
   end

   // Model state: one operation in flight, which finishes at a known edge
   bit m_active = 0;
   int m_end = 0;
   int p_q, p_r, p_dz, p_ov;
   int m_q = 0, m_r = 0, m_dz = 0, m_ov = 0;
   bit e_done = 0;

   // Advance the model by the edge that just occurred and compare all outputs
   always @(negedge clk) begin
      bit idle_b;
      if (!rst_n || !s_rstn) begin
         m_active = 0; e_done = 0;
         m_q = 0; m_r = 0; m_dz = 0; m_ov = 0;
      end else begin
         idle_b = !m_active;
         e_done = 0;
         if (m_active && edge_n == m_end) begin
            m_active = 0; e_done = 1;
            m_q = p_q; m_r = p_r; m_dz = p_dz; m_ov = p_ov;
         end
         if (idle_b && s_start) begin
            m_active = 1;
            m_end = edge_n + LAT;
            ref_div(sx(s_a), sx(s_b), p_q, p_r, p_dz, p_ov);
         end
      end
      chk("cyc_busy", int'(busy), int'(m_active));
      chk("cyc_done", int'(done), int'(e_done));
      chk("cyc_q",    sx(q),      m_q);
      chk("cyc_r",    sx(r),      m_r);
      chk("cyc_dbz",  int'(dbz),  m_dz);
      chk("cyc_ovf",  int'(ovf),  m_ov);
   end

   // Issue one operation (caller sits 2ns after a rising edge) and wait for done
   task automatic run(input int av, input int bv, output int lat,
                      output int qo, output int ro, output int dz, output int ov);
      bit got;
      start = 1'b1; a = W'(av); b = W'(bv);
      @(posedge clk);
      #2 start = 1'b0;
      got = 0; lat = 0;
      for (int i = 1; i <= 20 && !got; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            got = 1; lat = i;
         end
      end
      if (!got) chk("done_timeout", 0, 1);
      qo = sx(q); ro = sx(r); dz = int'(dbz); ov = int'(ovf);
      #1;
   endtask

   int lat, qo, ro, dz, ov;
   int rq, rr, rdz, rov;
   int nd;
   int t_done[2];
   int q_done[2];
   int r_done[2];

   initial begin
      // Pin the reference model itself
      ref_div(-7, 2, rq, rr, rdz, rov);  chk("model_q_m7_2", rq, -3); chk("model_r_m7_2", rr, -1);
      ref_div(7, -2, rq, rr, rdz, rov);  chk("model_q_7_m2", rq, -3); chk("model_r_7_m2", rr, 1);
      ref_div(5, 0, rq, rr, rdz, rov);   chk("model_dbz", rdz, 1);    chk("model_q_dbz", rq, -1);
      ref_div(-8, -1, rq, rr, rdz, rov); chk("model_ovf", rov, 1);    chk("model_q_ovf", rq, -8);

      repeat (2) @(posedge clk);
      #1;
      chk("rst_q", sx(q), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #2;

      // Abort mid-division with reset
      start = 1'b1; a = 4'd7; b = 4'd2;
      @(posedge clk);
      #2 start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_q", sx(q), 0);
      chk("abort_r", sx(r), 0);
      chk("abort_done", int'(done), 0);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #2;
      run(7, 2, lat, qo, ro, dz, ov);
      chk("post_abort_lat", lat, 5); chk("post_abort_q", qo, 3); chk("post_abort_r", ro, 1);

      // Sign combinations and special cases
      run(-7, 2, lat, qo, ro, dz, ov);  chk("m7_2_q", qo, -3); chk("m7_2_r", ro, -1); chk("m7_2_fl", dz + ov, 0);
      run(7, -2, lat, qo, ro, dz, ov);  chk("7_m2_q", qo, -3); chk("7_m2_r", ro, 1);
      run(-7, -2, lat, qo, ro, dz, ov); chk("m7_m2_q", qo, 3); chk("m7_m2_r", ro, -1);
      run(5, 0, lat, qo, ro, dz, ov);
      chk("dbz_q", qo, -1); chk("dbz_r", ro, 5); chk("dbz_flag", dz, 1); chk("dbz_ovf", ov, 0); chk("dbz_lat", lat, 5);
      run(-8, -1, lat, qo, ro, dz, ov);
      chk("ovf_q", qo, -8); chk("ovf_r", ro, 0); chk("ovf_flag", ov, 1); chk("ovf_dbz", dz, 0);
      run(-8, 1, lat, qo, ro, dz, ov);
      chk("m8_1_q", qo, -8); chk("m8_1_r", ro, 0); chk("m8_1_ovf", ov, 0);

      // start while busy is ignored, operand changes during CALC have no effect
      start = 1'b1; a = 4'd7; b = 4'd2;
      @(posedge clk);
      #2 start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 start = 1'b1; a = 4'd3; b = 4'd3;
      @(posedge clk);
      #2 start = 1'b0; a = 4'd1; b = 4'd1;
      nd = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            nd++; qo = sx(q); ro = sx(r);
         end
      end
      #1;
      chk("busy_ign_dones", nd, 1); chk("busy_ign_q", qo, 3); chk("busy_ign_r", ro, 1);

      // Back-to-back with start held high
      start = 1'b1; a = 4'd6; b = 4'd4;
      @(posedge clk);
      #2 a = W'(-5); b = 4'd3;
      nd = 0;
      for (int i = 1; i <= 20 && nd < 2; i++) begin
         @(posedge clk);
         #1;
         if (i == 6) start = 1'b0;
         if (done) begin
            t_done[nd] = i; q_done[nd] = sx(q); r_done[nd] = sx(r); nd++;
         end
      end
      #1;
      chk("b2b_count", nd, 2);
      if (nd == 2) begin
         chk("b2b_q0", q_done[0], 1);  chk("b2b_r0", r_done[0], 2);
         chk("b2b_q1", q_done[1], -1); chk("b2b_r1", r_done[1], -2);
         chk("b2b_t0", t_done[0], 5);  chk("b2b_gap", t_done[1] - t_done[0], 6);
      end
      repeat (3) @(posedge clk);
      #2;

      // Exhaustive sweep with algebraic checks
      for (int av = MINV; av <= MAXV; av++) begin
         for (int bv = MINV; bv <= MAXV; bv++) begin
            run(av, bv, lat, qo, ro, dz, ov);
            chk("sw_lat", lat, LAT);
            chk("sw_dbz", dz, int'(bv == 0));
            chk("sw_ovf", ov, int'(av == MINV && bv == -1));
            if (bv != 0) begin
               chk("sw_identity", (qo * bv + ro) & ((1 << W) - 1), av & ((1 << W) - 1));
               chk("sw_rmag", int'((ro < 0 ? -ro : ro) < (bv < 0 ? -bv : bv)), 1);
               chk("sw_rsign", int'(ro == 0 || ((ro < 0) == (av < 0))), 1);
            end else begin
               chk("sw_dbz_q", qo, -1);
               chk("sw_dbz_r", ro, av);
            end
         end
      end

      // Random traffic, checked cycle by cycle against the model
      for (int i = 0; i < 1500; i++) begin
         start = ($urandom_range(0, 2) == 0);
         a = W'($urandom);
         case ($urandom_range(0, 7))
            0:       b = '0;
            1:       b = '1;
            default: b = W'($urandom);
         endcase
         if ($urandom_range(0, 15) == 0) a = {1'b1, {(W-1){1'b0}}};
         @(posedge clk);
         #2;
      end
      start = 1'b0;
      repeat (LAT + 3) @(posedge clk);
      #2;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
